vip_ctrl_packet_decoder: RTL and testbench

- Parametrised successor to the clocked-video input packet state machine.
- Parses an Avalon-ST video stream carrying NPP symbols per beat (NPP = 1..9).
- Decodes control packets into committed width/height/interlace registers.
- Forwards video packets downstream with start-of-field and end-of-line markers, checks video packet length against the committed geometry, and discards all other packet types.

---
 rtl/vip_ctrl_packet_decoder.sv | 267 ++++++++++++++++++++++++++
 tb/tb_vip_ctrl_packet_decoder.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vip_ctrl_packet_decoder.sv
// Avalon-ST video packet decoder: commits control-packet geometry, forwards video beats with sop/eol/eop.
// Optional status counters (field_count, err_count) are enabled by defining VIP_CTRL_STATUS_COUNTERS_EN.
module vip_ctrl_packet_decoder #(
    parameter int         BPS               = 8,
    parameter int         NPP               = 1,
    parameter int         DIM_BITS          = 16,
    parameter int         DEFAULT_WIDTH     = 1920,
    parameter int         DEFAULT_HEIGHT    = 1080,
    parameter logic [3:0] DEFAULT_INTERLACE = 4'd0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BPS*NPP-1:0]    din_data,
    input  logic                  din_valid,
    input  logic                  din_sop,
    input  logic                  din_eop,
    output logic                  din_ready,
    output logic [BPS*NPP-1:0]    dout_data,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  dout_sop,
    output logic                  dout_eol,
    output logic                  dout_eop,
    output logic [DIM_BITS-1:0]   width_out,
    output logic [DIM_BITS-1:0]   height_out,
    output logic [3:0]            interlace_out,
    output logic                  ctrl_update,
    output logic                  err_short_ctrl,
    output logic                  err_early_eop,
    output logic                  err_late_eop
`ifdef VIP_CTRL_STATUS_COUNTERS_EN
    ,
    output logic [15:0]           field_count,
    output logic [15:0]           err_count
`endif
);

    typedef enum logic [1:0] {FIND_SOP, CTRL, VIDEO, DISCARD} state_t;

    state_t                state_q, state_d;
    logic [DIM_BITS-1:0]   width_q, width_d, height_q, height_d;
    logic [3:0]            ilace_q, ilace_d;
    logic [DIM_BITS-1:0]   sh_w_q, sh_w_d, sh_h_q, sh_h_d;
    logic [3:0]            sh_i_q, sh_i_d;
    logic [3:0]            nib_idx_q, nib_idx_d;
    logic [DIM_BITS-1:0]   bpl_q, bpl_d, vh_q, vh_d;
    logic [DIM_BITS-1:0]   beat_q, beat_d, line_q, line_d;
    logic                  first_q, first_d, done_q, done_d;
    logic [BPS*NPP-1:0]    dout_data_q, dout_data_d;
    logic                  dout_valid_q, dout_valid_d;
    logic                  dout_sop_q, dout_sop_d, dout_eol_q, dout_eol_d, dout_eop_q, dout_eop_d;
    logic                  upd_q, upd_d, es_q, es_d, ee_q, ee_d, el_q, el_d;
    logic                  ready_c, xfer, decode_sop, last_beat, last_line;

    // Once the field is complete, extra beats are dropped, so backpressure no longer applies.
    always_comb begin
        case (state_q)
            VIDEO:   ready_c = done_q | dout_ready | ~dout_valid_q;
            default: ready_c = 1'b1;
        endcase
    end

    assign din_ready = ready_c & ~rst;
    assign xfer      = din_valid & din_ready;
    assign last_beat = (beat_q == bpl_q - DIM_BITS'(1));
    assign last_line = (line_q == vh_q - DIM_BITS'(1));

    always_comb begin
        logic [3:0] nib;
        nib          = 4'd0;
        state_d      = state_q;
        width_d      = width_q;
        height_d     = height_q;
        ilace_d      = ilace_q;
        sh_w_d       = sh_w_q;
        sh_h_d       = sh_h_q;
        sh_i_d       = sh_i_q;
        nib_idx_d    = nib_idx_q;
        bpl_d        = bpl_q;
        vh_d         = vh_q;
        beat_d       = beat_q;
        line_d       = line_q;
        first_d      = first_q;
        done_d       = done_q;
        dout_data_d  = dout_data_q;
        dout_valid_d = dout_valid_q & ~dout_ready;
        dout_sop_d   = dout_sop_q;
        dout_eol_d   = dout_eol_q;
        dout_eop_d   = dout_eop_q;
        upd_d        = 1'b0;
        es_d         = 1'b0;
        ee_d         = 1'b0;
        el_d         = 1'b0;
        decode_sop   = 1'b0;

        case (state_q)
            FIND_SOP: begin
                if (xfer && din_sop) decode_sop = 1'b1;
            end
            CTRL: begin
                if (xfer && din_sop) begin
                    es_d       = 1'b1;
                    decode_sop = 1'b1;
                end else if (xfer) begin
                    for (int k = 0; k < NPP; k++) begin
                        nib = din_data[k*BPS +: 4];
                        if (nib_idx_d < 4'd4)      sh_w_d = (sh_w_d << 4) | DIM_BITS'(nib);
                        else if (nib_idx_d < 4'd8) sh_h_d = (sh_h_d << 4) | DIM_BITS'(nib);
                        else if (nib_idx_d == 4'd8) sh_i_d = nib;
                        if (nib_idx_d < 4'd9) nib_idx_d = nib_idx_d + 4'd1;
                    end
                    if (din_eop) begin
                        state_d = FIND_SOP;
                        if (nib_idx_d == 4'd9 && sh_w_d != '0 && sh_h_d != '0) begin
                            upd_d    = 1'b1;
                            width_d  = sh_w_d;
                            height_d = sh_h_d;
                            ilace_d  = sh_i_d;
                        end else begin
                            es_d = 1'b1;
                        end
                    end
                end
            end
            VIDEO: begin
                if (xfer && din_sop) begin
                    ee_d       = ~done_q;
                    decode_sop = 1'b1;
                end else if (xfer && done_q) begin
                    el_d    = 1'b1;
                    done_d  = 1'b0;
                    state_d = din_eop ? FIND_SOP : DISCARD;
                end else if (xfer) begin
                    dout_valid_d = 1'b1;
                    dout_data_d  = din_data;
                    dout_sop_d   = first_q;
                    dout_eol_d   = last_beat;
                    dout_eop_d   = din_eop | (last_beat & last_line);
                    first_d      = 1'b0;
                    if (last_beat) begin
                        beat_d = '0;
                        line_d = line_q + DIM_BITS'(1);
                    end else begin
                        beat_d = beat_q + DIM_BITS'(1);
                    end
                    if (last_beat && last_line) begin
                        if (din_eop) state_d = FIND_SOP;
                        else         done_d  = 1'b1;
                    end else if (din_eop) begin
                        ee_d    = 1'b1;
                        state_d = FIND_SOP;
                    end
                end
            end
            default: begin
                if (xfer && din_sop)      decode_sop = 1'b1;
                else if (xfer && din_eop) state_d    = FIND_SOP;
            end
        endcase

        // Header decode shared by every state that can see a new sop.
        if (decode_sop) begin
            state_d = FIND_SOP;
            done_d  = 1'b0;
            if (din_eop) begin
                if (din_data[3:0] == 4'hF) es_d = 1'b1;
            end else if (din_data[3:0] == 4'h0) begin
                state_d = VIDEO;
                bpl_d   = DIM_BITS'((32'(width_q) + 32'(NPP) - 32'd1) / 32'(NPP));
                vh_d    = height_q;
                beat_d  = '0;
                line_d  = '0;
                first_d = 1'b1;
            end else if (din_data[3:0] == 4'hF) begin
                state_d   = CTRL;
                nib_idx_d = 4'd0;
            end else begin
                state_d = DISCARD;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= FIND_SOP;
            width_q      <= DIM_BITS'(DEFAULT_WIDTH);
            height_q     <= DIM_BITS'(DEFAULT_HEIGHT);
            ilace_q      <= DEFAULT_INTERLACE;
            sh_w_q       <= '0;
            sh_h_q       <= '0;
            sh_i_q       <= '0;
            nib_idx_q    <= '0;
            bpl_q        <= '0;
            vh_q         <= '0;
            beat_q       <= '0;
            line_q       <= '0;
            first_q      <= 1'b0;
            done_q       <= 1'b0;
            dout_data_q  <= '0;
            dout_valid_q <= 1'b0;
            dout_sop_q   <= 1'b0;
            dout_eol_q   <= 1'b0;
            dout_eop_q   <= 1'b0;
            upd_q        <= 1'b0;
            es_q         <= 1'b0;
            ee_q         <= 1'b0;
            el_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            width_q      <= width_d;
            height_q     <= height_d;
            ilace_q      <= ilace_d;
            sh_w_q       <= sh_w_d;
            sh_h_q       <= sh_h_d;
            sh_i_q       <= sh_i_d;
            nib_idx_q    <= nib_idx_d;
            bpl_q        <= bpl_d;
            vh_q         <= vh_d;
            beat_q       <= beat_d;
            line_q       <= line_d;
            first_q      <= first_d;
            done_q       <= done_d;
            dout_data_q  <= dout_data_d;
            dout_valid_q <= dout_valid_d;
            dout_sop_q   <= dout_sop_d;
            dout_eol_q   <= dout_eol_d;
            dout_eop_q   <= dout_eop_d;
            upd_q        <= upd_d;
            es_q         <= es_d;
            ee_q         <= ee_d;
            el_q         <= el_d;
        end
    end

    assign dout_data      = dout_data_q;
    assign dout_valid     = dout_valid_q;
    assign dout_sop       = dout_sop_q;
    assign dout_eol       = dout_eol_q;
    assign dout_eop       = dout_eop_q;
    assign width_out      = width_q;
    assign height_out     = height_q;
    assign interlace_out  = ilace_q;
    assign ctrl_update    = upd_q;
    assign err_short_ctrl = es_q;
    assign err_early_eop  = ee_q;
    assign err_late_eop   = el_q;

`ifdef VIP_CTRL_STATUS_COUNTERS_EN
    logic [15:0] field_cnt_q, err_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            field_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            if (dout_valid_q && dout_ready && dout_eop_q && field_cnt_q != 16'hFFFF)
                field_cnt_q <= field_cnt_q + 16'd1;
            if ((es_q || ee_q || el_q) && err_cnt_q != 16'hFFFF)
                err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign field_count = field_cnt_q;
    assign err_count   = err_cnt_q;
`endif

endmodule

// File: tb/tb_vip_ctrl_packet_decoder.sv
// Self-checking bench for vip_ctrl_packet_decoder (NPP=2): directed cases plus randomized packets vs a packet-level model.
module tb_vip_ctrl_packet_decoder;
    localparam int BPS = 8;
    localparam int NPP = 2;
    localparam int DW  = BPS * NPP;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] din_data;
    logic          din_valid, din_sop, din_eop, din_ready;
    logic [DW-1:0] dout_data;
    logic          dout_valid, dout_ready, dout_sop, dout_eol, dout_eop;
    logic [15:0]   width_out, height_out;
    logic [3:0]    interlace_out;
    logic          ctrl_update, err_short_ctrl, err_early_eop, err_late_eop;

    always #5 clk = ~clk;

    vip_ctrl_packet_decoder #(
        .BPS(BPS), .NPP(NPP), .DIM_BITS(16),
        .DEFAULT_WIDTH(1920), .DEFAULT_HEIGHT(1080), .DEFAULT_INTERLACE(4'd0)
    ) dut (
        .clk(clk), .rst(rst),
        .din_data(din_data), .din_valid(din_valid), .din_sop(din_sop), .din_eop(din_eop),
        .din_ready(din_ready),
        .dout_data(dout_data), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .dout_sop(dout_sop), .dout_eol(dout_eol), .dout_eop(dout_eop),
        .width_out(width_out), .height_out(height_out), .interlace_out(interlace_out),
        .ctrl_update(ctrl_update), .err_short_ctrl(err_short_ctrl),
        .err_early_eop(err_early_eop), .err_late_eop(err_late_eop)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eol;
        logic          eop;
    } beat_t;

    beat_t         got_q[$];
    beat_t         exp_q[$];
    logic [DW-1:0] pkt[$];
    int            nq[$];
    int            tests = 0, fails = 0;
    int            n_upd, n_es, n_ee, n_el;
    int            e_upd, e_es, e_ee, e_el;
    int            m_w = 1920, m_h = 1080, m_i = 0;
    int            rmode = 0;
    bit            tgl = 1'b0;
    bit            hold_pend = 1'b0;
    beat_t         held;

    // Output monitor: records accepted beats and pulses, checks stability under backpressure.
    always @(negedge clk) begin
        #2;
        if (rst === 1'b1) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                tests++;
                assert (dout_valid === 1'b1 && {dout_data, dout_sop, dout_eol, dout_eop} === held)
                else begin
                    fails++;
                    $error("FAIL hold_stable: got v=%b beat=%h expected v=1 beat=%h",
                           dout_valid, {dout_data, dout_sop, dout_eol, dout_eop}, held);
                end
            end
            if (dout_valid === 1'b1 && dout_ready === 1'b1)
                got_q.push_back({dout_data, dout_sop, dout_eol, dout_eop});
            hold_pend = (dout_valid === 1'b1) && (dout_ready !== 1'b1);
            held      = {dout_data, dout_sop, dout_eol, dout_eop};
            if (ctrl_update === 1'b1)    n_upd++;
            if (err_short_ctrl === 1'b1) n_es++;
            if (err_early_eop === 1'b1)  n_ee++;
            if (err_late_eop === 1'b1)   n_el++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic nxt_ready();
        tgl = ~tgl;
        case (rmode)
            0:       return 1'b1;
            1:       return tgl;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic send_beat(input logic [DW-1:0] d, input logic s, input logic e);
        int guard = 0;
        bit got = 1'b0;
        while (!got) begin
            @(negedge clk);
            din_valid  = 1'b1;
            din_data   = d;
            din_sop    = s;
            din_eop    = e;
            dout_ready = nxt_ready();
            #1;
            got = (din_ready === 1'b1);
            guard++;
            if (!got && guard > 100) begin
                tests++;
                fails++;
                $error("FAIL din_ready_timeout: got din_ready=%b expected 1 within 100 cycles", din_ready);
                got = 1'b1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            din_valid  = 1'b0;
            din_sop    = 1'b0;
            din_eop    = 1'b0;
            dout_ready = 1'b1;
        end
    endtask

    task automatic send_pkt(input logic [3:0] typ, input bit with_eop);
        logic [DW-1:0] hdr;
        hdr      = DW'($urandom);
        hdr[3:0] = typ;
        send_beat(hdr, 1'b1, with_eop && pkt.size() == 0);
        foreach (pkt[j]) send_beat(pkt[j], 1'b0, with_eop && j == pkt.size() - 1);
    endtask

    task automatic begin_pkt();
        got_q.delete();
        exp_q.delete();
        n_upd = 0; n_es = 0; n_ee = 0; n_el = 0;
        e_upd = 0; e_es = 0; e_ee = 0; e_el = 0;
    endtask

    // Two nibbles per beat, low symbol first; odd counts are padded with a random nibble.
    task automatic build_ctrl();
        int hi;
        pkt.delete();
        for (int i = 0; i < nq.size(); i += 2) begin
            hi = (i + 1 < nq.size()) ? nq[i+1] : int'($urandom_range(0, 15));
            pkt.push_back({4'($urandom), 4'(hi), 4'($urandom), 4'(nq[i])});
        end
    endtask

    task automatic build_video(input int n);
        pkt.delete();
        for (int i = 0; i < n; i++) pkt.push_back(DW'($urandom));
    endtask

    function automatic void model_ctrl();
        int nibs[$];
        int w = 0, h = 0, il = 0;
        foreach (pkt[j])
            for (int k = 0; k < NPP; k++) nibs.push_back(int'(pkt[j][k*BPS +: 4]));
        if (nibs.size() >= 9) begin
            for (int i = 0; i < 4; i++) begin
                w = w * 16 + nibs[i];
                h = h * 16 + nibs[4+i];
            end
            il = nibs[8];
        end
        if (nibs.size() >= 9 && w != 0 && h != 0) begin
            e_upd++;
            m_w = w; m_h = h; m_i = il;
        end else begin
            e_es++;
        end
    endfunction

    function automatic void model_video(input bit term_sop);
        int bpl   = (m_w + NPP - 1) / NPP;
        int total = bpl * m_h;
        int n     = pkt.size();
        beat_t b;
        for (int i = 0; i < n && i < total; i++) begin
            b.data = pkt[i];
            b.sop  = (i == 0);
            b.eol  = ((i % bpl) == bpl - 1);
            b.eop  = (i == total - 1) || (!term_sop && i == n - 1);
            exp_q.push_back(b);
        end
        if (n < total && (term_sop || n > 0)) e_ee++;
        if (n > total) e_el++;
    endfunction

    task automatic finish_pkt(input string name);
        idle(6);
        chk({name, "_nbeats"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_beat%0d", name, i), got_q[i], exp_q[i]);
        chk({name, "_ctrl_update"}, n_upd, e_upd);
        chk({name, "_err_short"}, n_es, e_es);
        chk({name, "_err_early"}, n_ee, e_ee);
        chk({name, "_err_late"}, n_el, e_el);
        chk({name, "_width"}, width_out, m_w);
        chk({name, "_height"}, height_out, m_h);
        chk({name, "_interlace"}, interlace_out, m_i);
        $display("[TB] %s: %0d beats out, upd=%0d es=%0d ee=%0d el=%0d", name,
                 got_q.size(), n_upd, n_es, n_ee, n_el);
    endtask

    task automatic ctrl_wh(input int w, input int h, input int il, input int extra);
        nq.delete();
        for (int i = 3; i >= 0; i--) nq.push_back((w >> (4 * i)) & 15);
        for (int i = 3; i >= 0; i--) nq.push_back((h >> (4 * i)) & 15);
        nq.push_back(il);
        for (int i = 0; i < extra; i++) nq.push_back(int'($urandom_range(0, 15)));
        build_ctrl();
    endtask

    initial begin
        int kind, bpl, total, n;
        rst = 1'b1; din_valid = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
        din_data = '0; dout_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_din_ready", din_ready, 0);
        chk("rst_width", width_out, 1920);
        chk("rst_height", height_out, 1080);
        chk("rst_interlace", interlace_out, 0);
        chk("rst_pulses", {ctrl_update, err_short_ctrl, err_early_eop, err_late_eop}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("post_rst_din_ready", din_ready, 1);
        chk("post_rst_dout_valid", dout_valid, 0);

        // 640x480, interlace 3
        begin_pkt();
        nq = '{0, 2, 8, 0, 0, 1, 14, 0, 3};
        build_ctrl(); model_ctrl(); send_pkt(4'hF, 1'b1);
        finish_pkt("ctrl_640x480");

        // short control packet: 6 nibbles
        begin_pkt();
        nq = '{1, 2, 3, 4, 5, 6};
        build_ctrl(); model_ctrl(); send_pkt(4'hF, 1'b1);
        finish_pkt("ctrl_short");

        begin_pkt();
        ctrl_wh(4, 2, 5, 0); model_ctrl(); send_pkt(4'hF, 1'b1);
        finish_pkt("ctrl_4x2");

        begin_pkt();
        build_video(4); model_video(1'b0); send_pkt(4'h0, 1'b1);
        finish_pkt("video_exact");

        begin_pkt();
        build_video(6); model_video(1'b0); send_pkt(4'h0, 1'b1);
        build_video(4); model_video(1'b0); send_pkt(4'h0, 1'b1);
        finish_pkt("video_late_then_ok");

        rmode = 1;
        begin_pkt();
        build_video(2); model_video(1'b0); send_pkt(4'h0, 1'b1);
        finish_pkt("video_early_toggle");

        // video cut short by a new sop, followed by a complete field
        begin_pkt();
        build_video(2); model_video(1'b1); send_pkt(4'h0, 1'b0);
        build_video(4); model_video(1'b0); send_pkt(4'h0, 1'b1);
        finish_pkt("video_sop_terminated");

        for (int t = 0; t < 40; t++) begin
            kind  = $urandom_range(0, 9);
            rmode = $urandom_range(0, 2);
            begin_pkt();
            if (kind <= 3) begin
                bpl   = (m_w + NPP - 1) / NPP;
                total = bpl * m_h;
                n     = $urandom_range((total > 3) ? total - 3 : 0, total + 3);
                build_video(n); model_video(1'b0); send_pkt(4'h0, 1'b1);
            end else if (kind <= 6) begin
                ctrl_wh($urandom_range(1, 8), $urandom_range(1, 4), $urandom_range(0, 15),
                        $urandom_range(0, 4));
                model_ctrl(); send_pkt(4'hF, 1'b1);
            end else if (kind == 7) begin
                nq.delete();
                n = $urandom_range(0, 8);
                for (int i = 0; i < n; i++) nq.push_back(int'($urandom_range(0, 15)));
                build_ctrl(); model_ctrl(); send_pkt(4'hF, 1'b1);
            end else if (kind == 8) begin
                build_video($urandom_range(0, 4));
                send_pkt(4'($urandom_range(1, 14)), 1'b1);
            end else begin
                ctrl_wh(0, $urandom_range(1, 4), 1, 0);
                model_ctrl(); send_pkt(4'hF, 1'b1);
            end
            finish_pkt($sformatf("rand%0d_k%0d", t, kind));
        end

        // reset in the middle of a video packet
        rmode = 0;
        build_video(3);
        send_pkt(4'h0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_dout_valid", dout_valid, 0);
        chk("midrst_din_ready", din_ready, 0);
        chk("midrst_width", width_out, 1920);
        chk("midrst_height", height_out, 1080);
        chk("midrst_interlace", interlace_out, 0);
        @(negedge clk);
        rst = 1'b0;
        din_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("midrst_release_ready", din_ready, 1);
        chk("midrst_release_valid", dout_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
